execute_stage: RTL and testbench

- Pipeline stage directly downstream of decode.
- Consumes decode's registered ALU opcode/operands, store data and writeback/memory control, and computes the ALU result.
- Issues the data-RAM request for LW/SW.
- Holds the EX/MEM pipeline register that feeds the memory stage, and exports current-cycle forwarding info to the hazard logic.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/exe_alu.sv | 34 +++
 rtl/execute_stage.sv | 148 ++++++++++++++
 tb/tb_execute_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcode encodings (identical to decode) and data-RAM byte enables.
package cpu_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_SLT  = 4'h4;
    localparam logic [3:0] ALU_SLTU = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SAL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;
    localparam logic [3:0] ALU_XOR  = 4'hB;
    localparam logic [3:0] ALU_NOR  = 4'hC;

    localparam logic [3:0] WEN_WORD = 4'b1111;

endpackage

// File: rtl/exe_alu.sv
// Combinational 32-bit ALU; shifts take their amount from A[4:0] and shift B.
module exe_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  aluop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = src_a[4:0];

    always_comb begin
        result = 32'd0;
        case (aluop)
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: result = {31'd0, src_a < src_b};
            ALU_SLL:  result = src_b << shamt;
            ALU_SRL:  result = src_b >> shamt;
            ALU_SAL:  result = src_b << shamt;
            ALU_SRA:  result = $unsigned($signed(src_b) >>> shamt);
            ALU_LUI:  result = {src_b[15:0], 16'd0};
            ALU_XOR:  result = src_a ^ src_b;
            ALU_NOR:  result = ~(src_a | src_b);
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, data-RAM request and the EX/MEM pipeline register.
// Optional performance counters are enabled with `define EXE_PERF_CNT_EN.
module execute_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              de_valid,
    input  logic [3:0]        de_aluop,
    input  logic [31:0]       de_alusrc1,
    input  logic [31:0]       de_alusrc2,
    input  logic [31:0]       de_rt_content,
    input  logic              de_dramen,
    input  logic [3:0]        de_dramwen,
    input  logic              de_wen,
    input  logic [4:0]        de_regsrc,
    input  logic              de_is_load,
    input  logic [31:0]       de_pc,
    input  logic              ms_allowin,
    input  logic              flush,
    output logic              es_allowin,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [31:0]       data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    output logic              es_valid,
    output logic [31:0]       es_result,
    output logic              es_wen,
    output logic [4:0]        es_regdst,
    output logic              es_is_load,
    output logic [31:0]       es_pc,
    output logic              fwd_wen,
    output logic [4:0]        fwd_regdst,
    output logic [31:0]       fwd_result
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_inst_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

    // Handshake: decode's instruction moves into EX/MEM on a rising edge when
    // de_valid & es_allowin; es_allowin mirrors ms_allowin since EX/MEM is the only storage.
    logic        adv;
    logic        live;
    logic [31:0] alu_result;

    assign adv  = ms_allowin;
    assign live = de_valid & ~flush;

    exe_alu u_alu (
        .aluop  (de_aluop),
        .src_a  (de_alusrc1),
        .src_b  (de_alusrc2),
        .result (alu_result)
    );

    assign es_allowin = ms_allowin;
    assign fwd_wen    = live & de_wen;
    assign fwd_regdst = de_regsrc;
    assign fwd_result = alu_result;

    // RAM fires only on the advancing cycle so a stalled store writes exactly once.
    assign data_sram_en    = live & de_dramen & adv & resetn;
    assign data_sram_wen   = data_sram_en ? de_dramwen : 4'd0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = de_rt_content;

    logic        es_valid_q,   es_valid_d;
    logic [31:0] es_result_q,  es_result_d;
    logic        es_wen_q,     es_wen_d;
    logic [4:0]  es_regdst_q,  es_regdst_d;
    logic        es_is_load_q, es_is_load_d;
    logic [31:0] es_pc_q,      es_pc_d;

    always_comb begin
        es_valid_d   = es_valid_q;
        es_result_d  = es_result_q;
        es_wen_d     = es_wen_q;
        es_regdst_d  = es_regdst_q;
        es_is_load_d = es_is_load_q;
        es_pc_d      = es_pc_q;
        if (adv) begin
            es_valid_d   = live;
            es_result_d  = alu_result;
            es_wen_d     = de_wen & live;
            es_regdst_d  = de_regsrc;
            es_is_load_d = de_is_load & live;
            es_pc_d      = de_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q   <= 1'b0;
            es_result_q  <= 32'd0;
            es_wen_q     <= 1'b0;
            es_regdst_q  <= 5'd0;
            es_is_load_q <= 1'b0;
            es_pc_q      <= 32'd0;
        end else begin
            es_valid_q   <= es_valid_d;
            es_result_q  <= es_result_d;
            es_wen_q     <= es_wen_d;
            es_regdst_q  <= es_regdst_d;
            es_is_load_q <= es_is_load_d;
            es_pc_q      <= es_pc_d;
        end
    end

    assign es_valid   = es_valid_q;
    assign es_result  = es_result_q;
    assign es_wen     = es_wen_q;
    assign es_regdst  = es_regdst_q;
    assign es_is_load = es_is_load_q;
    assign es_pc      = es_pc_q;

`ifdef EXE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_inst_cnt_q,  perf_inst_cnt_d;
    logic [CNT_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_inst_cnt_d  = perf_inst_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (live & adv)
            perf_inst_cnt_d = perf_inst_cnt_q + 1'b1;
        if (de_valid & ~adv)
            perf_stall_cnt_d = perf_stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_inst_cnt_q  <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_inst_cnt_q  <= perf_inst_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_inst_cnt  = perf_inst_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: random stimulus against a behavioural model,
// plus directed literal checks from the test plan.
module tb_execute_stage;

    logic        clk;
    logic        resetn;
    logic        de_valid;
    logic [3:0]  de_aluop;
    logic [31:0] de_alusrc1;
    logic [31:0] de_alusrc2;
    logic [31:0] de_rt_content;
    logic        de_dramen;
    logic [3:0]  de_dramwen;
    logic        de_wen;
    logic [4:0]  de_regsrc;
    logic        de_is_load;
    logic [31:0] de_pc;
    logic        ms_allowin;
    logic        flush;
    logic        es_allowin;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        es_valid;
    logic [31:0] es_result;
    logic        es_wen;
    logic [4:0]  es_regdst;
    logic        es_is_load;
    logic [31:0] es_pc;
    logic        fwd_wen;
    logic [4:0]  fwd_regdst;
    logic [31:0] fwd_result;
`ifdef EXE_PERF_CNT_EN
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    execute_stage #(.CNT_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .de_valid        (de_valid),
        .de_aluop        (de_aluop),
        .de_alusrc1      (de_alusrc1),
        .de_alusrc2      (de_alusrc2),
        .de_rt_content   (de_rt_content),
        .de_dramen       (de_dramen),
        .de_dramwen      (de_dramwen),
        .de_wen          (de_wen),
        .de_regsrc       (de_regsrc),
        .de_is_load      (de_is_load),
        .de_pc           (de_pc),
        .ms_allowin      (ms_allowin),
        .flush           (flush),
        .es_allowin      (es_allowin),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_valid        (es_valid),
        .es_result       (es_result),
        .es_wen          (es_wen),
        .es_regdst       (es_regdst),
        .es_is_load      (es_is_load),
        .es_pc           (es_pc),
        .fwd_wen         (fwd_wen),
        .fwd_regdst      (fwd_regdst),
        .fwd_result      (fwd_result)
`ifdef EXE_PERF_CNT_EN
        ,
        .perf_inst_cnt   (perf_inst_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference ALU written from the opcode table, shifts done one bit at a time.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(a % 32);
        r = 32'd0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a + (~b) + 32'd1;
            4'h4: begin
                if (a[31] != b[31]) r = a[31] ? 32'd1 : 32'd0;
                else                r = (a < b) ? 32'd1 : 32'd0;
            end
            4'h5: r = (a < b) ? 32'd1 : 32'd0;
            4'h6, 4'h8: begin r = b; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
            4'h7: begin r = b; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
            4'h9: begin r = b; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
            4'hA: r = b * 32'd65536;
            4'hB: r = a ^ b;
            4'hC: r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // ---------------- behavioural model + compare process ----------------
    logic [71:0] m_state;
    logic [71:0] exp_q[$];

    function automatic logic [71:0] next_state();
        logic v;
        v = de_valid && !flush;
        return {v, ref_alu(de_aluop, de_alusrc1, de_alusrc2), de_wen && v, de_regsrc,
                de_is_load && v, de_pc};
    endfunction

    function automatic logic [107:0] exp_comb();
        logic live;
        logic en;
        live = de_valid && !flush;
        en   = live && de_dramen && ms_allowin && resetn;
        return {live && de_wen, de_regsrc, ref_alu(de_aluop, de_alusrc1, de_alusrc2),
                ms_allowin, en, en ? de_dramwen : 4'd0,
                ref_alu(de_aluop, de_alusrc1, de_alusrc2), de_rt_content};
    endfunction

    initial m_state = '0;
    always @(negedge resetn) m_state = '0;

    always @(posedge clk) begin
        if (resetn) begin
            if (ms_allowin) m_state = next_state();
        end else begin
            m_state = '0;
        end
        exp_q.push_back(m_state);
        #1;
        check("es_regs", {56'd0, es_valid, es_result, es_wen, es_regdst, es_is_load, es_pc},
              {56'd0, exp_q.pop_front()});
    end

    always @(negedge clk) begin
        #2;
        check("comb_outs",
              {20'd0, fwd_wen, fwd_regdst, fwd_result, es_allowin, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata},
              {20'd0, exp_comb()});
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ms, input logic fl);
        @(negedge clk);
        de_valid   = v;
        de_aluop   = op;
        de_alusrc1 = a;
        de_alusrc2 = b;
        ms_allowin = ms;
        flush      = fl;
    endtask

    task automatic idle_inputs();
        de_valid = 0; de_aluop = 0; de_alusrc1 = 0; de_alusrc2 = 0; de_rt_content = 0;
        de_dramen = 0; de_dramwen = 0; de_wen = 0; de_regsrc = 0; de_is_load = 0; de_pc = 0;
        ms_allowin = 1; flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic drive_random();
        @(negedge clk);
        de_valid      = ($urandom_range(0, 3) != 0);
        de_aluop      = 4'($urandom_range(0, 15));
        de_alusrc1    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) | (32'($urandom) & 32'hFFFF_FFE0) : $urandom;
        de_alusrc2    = $urandom;
        de_rt_content = $urandom;
        de_dramen     = ($urandom_range(0, 2) == 0);
        de_dramwen    = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
        de_wen        = ($urandom_range(0, 1) != 0);
        de_regsrc     = 5'($urandom_range(0, 31));
        de_is_load    = ($urandom_range(0, 1) != 0);
        de_pc         = $urandom & 32'hFFFF_FFFC;
        ms_allowin    = ($urandom_range(0, 3) != 0);
        flush         = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int en_cnt;
        logic [31:0] held_result;
        logic [31:0] held_pc;
        idle_inputs();
        resetn = 0;
        #1;
        check("reset_es_valid", {127'd0, es_valid}, 128'd0);
        check("reset_es_result", {96'd0, es_result}, 128'd0);
        check("reset_sram_en", {127'd0, data_sram_en}, 128'd0);
        repeat (2) @(negedge clk);
        resetn = 1;

`ifdef EXE_PERF_CNT_EN
        for (int i = 0; i < 5; i++) drive(1, 4'h2, i, 1, 1, 0);
        for (int i = 0; i < 2; i++) drive(1, 4'h2, 0, 0, 0, 0);
        drive(0, 4'h0, 0, 0, 1, 0);
        #1;
        check("perf_inst", {96'd0, perf_inst_cnt}, 128'd5);
        check("perf_stall", {96'd0, perf_stall_cnt}, 128'd2);
        do_reset();
        #1;
        check("perf_inst_rst", {96'd0, perf_inst_cnt}, 128'd0);
        check("perf_stall_rst", {96'd0, perf_stall_cnt}, 128'd0);
`endif

        // ADD overflow wraps; result forwarded same cycle and registered next edge.
        de_wen = 1; de_regsrc = 5'd7; de_pc = 32'h0000_0040;
        drive(1, 4'h2, 32'h7FFF_FFFF, 32'd1, 1, 0);
        #1;
        check("add_fwd", {96'd0, fwd_result}, {96'd0, 32'h8000_0000});
        @(posedge clk); #1;
        check("add_es_result", {96'd0, es_result}, {96'd0, 32'h8000_0000});
        check("add_es_valid", {127'd0, es_valid}, 128'd1);

        drive(1, 4'h4, 32'hFFFF_FFFF, 32'd0, 1, 0); #1;
        check("slt", {96'd0, fwd_result}, 128'd1);
        drive(1, 4'h5, 32'hFFFF_FFFF, 32'd0, 1, 0); #1;
        check("sltu", {96'd0, fwd_result}, 128'd0);
        drive(1, 4'h9, 32'd4, 32'h8000_0000, 1, 0); #1;
        check("sra", {96'd0, fwd_result}, {96'd0, 32'hF800_0000});
        drive(1, 4'hA, 32'd0, 32'h0000_1234, 1, 0); #1;
        check("lui", {96'd0, fwd_result}, {96'd0, 32'h1234_0000});
        drive(1, 4'h7, 32'hFFFF_FFE4, 32'h8000_0000, 1, 0); #1;
        check("srl_upper_ignored", {96'd0, fwd_result}, {96'd0, 32'h0800_0000});

        // Store stalled three cycles: exactly one RAM request, on the advancing cycle.
        de_wen = 0; de_dramen = 1; de_dramwen = 4'hF; de_rt_content = 32'hDEAD_BEEF;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h2, 32'h100, 32'd8, (i == 3), 0);
            #1;
            if (data_sram_en) begin
                en_cnt++;
                check("sw_req", {60'd0, data_sram_wen, data_sram_addr, data_sram_wdata},
                      {60'd0, 4'hF, 32'h108, 32'hDEAD_BEEF});
            end
        end
        drive(0, 4'h0, 0, 0, 1, 0); #1;
        if (data_sram_en) en_cnt++;
        check("sw_once", 128'(en_cnt), 128'd1);
        de_dramen = 0; de_dramwen = 0;

        // Stall hold: es_* frozen while decode outputs change.
        de_wen = 1; de_regsrc = 5'd3; de_pc = 32'h0000_0200;
        drive(1, 4'h1, 32'h00F0, 32'h000F, 1, 0);
        @(posedge clk); #1;
        held_result = es_result;
        held_pc     = es_pc;
        check("pre_stall_result", {96'd0, held_result}, {96'd0, 32'h0000_00FF});
        de_regsrc = 5'd9; de_pc = 32'h0000_0300;
        for (int i = 0; i < 3; i++) drive(1, 4'hB, $urandom, $urandom, 0, 0);
        @(posedge clk); #1;
        check("stall_hold", {64'd0, es_result, es_pc}, {64'd0, 32'h0000_00FF, 32'h0000_0200});
        drive(1, 4'h3, 32'd10, 32'd3, 1, 0);
        @(posedge clk); #1;
        check("stall_release", {91'd0, es_regdst, es_result}, {91'd0, 5'd9, 32'd7});

        // Flush with an advancing store: bubble, no RAM access, no forwarding.
        de_dramen = 1; de_dramwen = 4'hF; de_wen = 1;
        drive(1, 4'h2, 32'd4, 32'd4, 1, 1); #1;
        check("flush_comb", {126'd0, data_sram_en, fwd_wen}, 128'd0);
        @(posedge clk); #1;
        check("flush_regs", {126'd0, es_valid, es_wen}, 128'd0);
        de_dramen = 0; de_dramwen = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) drive_random();

        // Asynchronous reset mid-stall discards the held instruction.
        idle_inputs();
        de_wen = 1;
        drive(1, 4'h2, 32'd1, 32'd1, 1, 0);
        drive(1, 4'h2, 32'd5, 32'd5, 0, 0);
        @(posedge clk); #1;
        check("pre_reset_valid", {127'd0, es_valid}, 128'd1);
        #2;
        resetn = 0;
        #1;
        check("async_reset", {62'd0, es_valid, es_wen, es_result, es_pc}, 128'd0);
        @(negedge clk);
        resetn = 1;
        drive(0, 4'h0, 0, 0, 1, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
